// File: rtl/round_robin_switch_allocator_pkg.sv
// Shared state encoding for the round-robin switch allocator.
package switch_alloc_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GRANT = 3'd2,
    ST_HOLD  = 3'd3
  } alloc_state_e;

endpackage

// File: rtl/round_robin_switch_allocator_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// above the pointer, wrapping to index 0.
module rr_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = 3
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic w_found;

  // Two ordered passes: indices >= pointer first, then the wrapped lower part.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!w_found && i_req[j] && (32'(i_ptr) <= j)) begin
        o_grant[j] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!w_found && i_req[j] && (j < 32'(i_ptr))) begin
        o_grant[j] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_switch_allocator.sv
// Per-input IDLE/REQ/GRANT/HOLD allocator with one round-robin arbiter per output.
// Optional forced release of long holds: define SWITCH_ALLOC_HOLD_TIMEOUT_EN.
module round_robin_switch_allocator
  import switch_alloc_pkg::*;
#(
  parameter int unsigned INPUTS        = 5,
  parameter int unsigned OUTPUTS       = 5,
  parameter int unsigned REQUEST_WIDTH = $clog2(OUTPUTS),
  parameter int unsigned SEL_WIDTH     = $clog2(INPUTS),
  parameter int unsigned HOLD_TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS-1:0]            routeReserveRequestValid,
  input  logic [INPUTS*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [INPUTS-1:0]            routeRelieve,
  output logic [INPUTS-1:0]            routeReserveStatus,
  output logic [OUTPUTS*SEL_WIDTH-1:0] routeSelect,
  output logic [OUTPUTS-1:0]           outputBusy,
  output logic [INPUTS-1:0]            PortReserved,
  output logic [INPUTS-1:0]            holdTimeout
);

  alloc_state_e             r_state     [INPUTS];
  alloc_state_e             w_state_nxt [INPUTS];
  logic [REQUEST_WIDTH-1:0] r_dest      [INPUTS];
  logic [OUTPUTS-1:0]       r_busy;
  logic [SEL_WIDTH-1:0]     r_sel       [OUTPUTS];
  logic [SEL_WIDTH-1:0]     r_ptr       [OUTPUTS];
  logic [INPUTS-1:0]        w_req       [OUTPUTS];
  logic [INPUTS-1:0]        w_gnt       [OUTPUTS];
  logic [SEL_WIDTH-1:0]     w_win_idx   [OUTPUTS];
  logic [OUTPUTS-1:0]       w_out_gnt;
  logic [OUTPUTS-1:0]       w_clr;
  logic [INPUTS-1:0]        w_won;
  logic [INPUTS-1:0]        w_release;
  logic [INPUTS-1:0]        w_tmo;

  // Only still-valid REQ inputs compete, so a withdraw never races a grant.
  always_comb begin
    for (int unsigned o = 0; o < OUTPUTS; o++) begin
      w_req[o] = '0;
      for (int unsigned i = 0; i < INPUTS; i++) begin
        w_req[o][i] = !r_busy[o] && (r_state[i] == ST_REQ) &&
                      routeReserveRequestValid[i] && (32'(r_dest[i]) == o);
      end
    end
  end

  for (genvar o = 0; o < OUTPUTS; o++) begin : g_arb
    rr_arbiter #(
      .N     (INPUTS),
      .PTR_W (SEL_WIDTH)
    ) u_arb (
      .i_req   (w_req[o]),
      .i_ptr   (r_ptr[o]),
      .o_grant (w_gnt[o])
    );
  end

  always_comb begin
    w_won = '0;
    for (int unsigned o = 0; o < OUTPUTS; o++) begin
      w_win_idx[o] = '0;
      w_out_gnt[o] = |w_gnt[o];
      for (int unsigned i = 0; i < INPUTS; i++) begin
        if (w_gnt[o][i]) begin
          w_win_idx[o] = SEL_WIDTH'(i);
          w_won[i]     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_release = '0;
    w_clr     = '0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE:  if (routeReserveRequestValid[i]) w_state_nxt[i] = ST_REQ;
        ST_REQ: begin
          if (!routeReserveRequestValid[i]) w_state_nxt[i] = ST_IDLE;
          else if (w_won[i])                w_state_nxt[i] = ST_GRANT;
        end
        ST_GRANT: w_state_nxt[i] = ST_HOLD;
        ST_HOLD: begin
          if (routeRelieve[i] || w_tmo[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_release[i]   = 1'b1;
          end
        end
        default:  w_state_nxt[i] = ST_IDLE;
      endcase
      for (int unsigned o = 0; o < OUTPUTS; o++) begin
        if (w_release[i] && (32'(r_dest[i]) == o)) w_clr[o] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < INPUTS; i++) begin
        r_state[i] <= ST_IDLE;
        r_dest[i]  <= '0;
      end
      for (int unsigned o = 0; o < OUTPUTS; o++) begin
        r_sel[o] <= '0;
        r_ptr[o] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int unsigned i = 0; i < INPUTS; i++) begin
        r_state[i] <= w_state_nxt[i];
        if ((r_state[i] == ST_IDLE) && routeReserveRequestValid[i])
          r_dest[i] <= routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH];
      end
      for (int unsigned o = 0; o < OUTPUTS; o++) begin
        if (w_out_gnt[o]) begin
          r_sel[o] <= w_win_idx[o];
          r_ptr[o] <= (32'(w_win_idx[o]) == INPUTS - 1) ? '0 : w_win_idx[o] + 1'b1;
        end
      end
      r_busy <= (r_busy & ~w_clr) | w_out_gnt;
    end
  end

`ifdef SWITCH_ALLOC_HOLD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_TIMEOUT + 1);

  logic [CNT_W-1:0]  r_hcnt [INPUTS];
  logic [INPUTS-1:0] r_tmo;

  always_comb begin
    for (int unsigned i = 0; i < INPUTS; i++) begin
      w_tmo[i] = (r_state[i] == ST_HOLD) && !routeRelieve[i] &&
                 (32'(r_hcnt[i]) == HOLD_TIMEOUT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < INPUTS; i++) r_hcnt[i] <= '0;
      r_tmo <= '0;
    end else begin
      for (int unsigned i = 0; i < INPUTS; i++) begin
        if ((r_state[i] == ST_HOLD) && (w_state_nxt[i] == ST_HOLD))
          r_hcnt[i] <= r_hcnt[i] + 1'b1;
        else
          r_hcnt[i] <= '0;
      end
      r_tmo <= w_tmo;
    end
  end

  assign holdTimeout = r_tmo;
`else
  assign w_tmo       = '0;
  assign holdTimeout = '0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < INPUTS; i++) begin
      routeReserveStatus[i] = (r_state[i] == ST_GRANT);
      PortReserved[i]       = (r_state[i] == ST_HOLD);
    end
    for (int unsigned o = 0; o < OUTPUTS; o++) begin
      routeSelect[o*SEL_WIDTH +: SEL_WIDTH] = r_sel[o];
    end
  end

  assign outputBusy = r_busy;

endmodule
